// File: rtl/piece_scheduler.sv
// piece_scheduler
//   Picks Tetris pieces using 7-bag rules. The free-running randomizer is
//   sampled every cycle while the queue has room. Each id 0..6 is issued
//   exactly once per bag. Accepted ids are queued so the game FSM always
//   sees a current piece and a preview.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   rand_in[2:0]   randomizer output, sampled every cycle while filling
//   piece_take     game FSM consumes the head piece (1-cycle pulse)
//   piece_valid    head entry valid (queue_count >= 1)
//   piece_id[2:0]  head id, 0 when !piece_valid
//   preview_valid  second entry valid (queue_count >= 2)
//   preview_id     second entry id, 0 when !preview_valid
//   queue_count    entries held, 0..QUEUE_DEPTH
//   bag_mask[6:0]  bit i set = piece i already issued in the current bag
//
// States
//   state  | meaning
//   S_FILL | queue has room; rand_in sampled every cycle
//   S_FULL | queue holds QUEUE_DEPTH entries; no sampling until a take

module piece_scheduler #(
    parameter int QUEUE_DEPTH = 3,
    parameter int MAX_RETRY   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] rand_in,
    input  logic       piece_take,
    output logic       piece_valid,
    output logic [2:0] piece_id,
    output logic       preview_valid,
    output logic [2:0] preview_id,
    output logic [2:0] queue_count,
    output logic [6:0] bag_mask
);

    localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
    localparam logic [2:0]    DEPTH_C    = 3'(QUEUE_DEPTH);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    fifo_q [QUEUE_DEPTH];
    logic [2:0]    fifo_d [QUEUE_DEPTH];
    logic [2:0]    count_q, count_d;
    logic [6:0]    bag_q, bag_d;
    logic [RW-1:0] retry_q, retry_d;

    logic       take_eff;
    logic       sampling;
    logic [7:0] mask_ext;
    logic       rand_rej;
    logic       force_pick;
    logic       push;
    logic [2:0] low_clear;
    logic [2:0] pick_id;
    logic [2:0] count_mid;
    logic [6:0] bag_set;

    // Id 7 is never a legal piece, so it is treated as permanently issued.
    assign mask_ext   = {1'b1, bag_q};
    assign take_eff   = piece_take && (count_q != 3'd0);
    assign sampling   = (state_q == S_FILL);
    assign rand_rej   = mask_ext[rand_in];
    assign force_pick = rand_rej && (retry_q == RETRY_LAST);
    assign push       = sampling && (!rand_rej || force_pick);
    assign pick_id    = rand_rej ? low_clear : rand_in;

    // The bag is cleared as soon as it would become full, so at least one
    // bit is always clear here.
    always_comb begin
        low_clear = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (!bag_q[i]) begin
                low_clear = 3'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        fifo_d    = fifo_q;
        count_d   = count_q;
        bag_d     = bag_q;
        retry_d   = retry_q;
        bag_set   = bag_q;
        count_mid = count_q;

        if (take_eff) begin
            for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
                fifo_d[i] = fifo_q[i + 1];
            end
            fifo_d[QUEUE_DEPTH - 1] = 3'd0;
            count_mid = count_q - 3'd1;
        end

        // A push lands behind whatever survives this cycle's pop.
        if (push) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (count_mid == 3'(i)) begin
                    fifo_d[i] = pick_id;
                end
            end
            bag_set = bag_q | (7'b1 << pick_id);
            bag_d   = (bag_set == 7'h7F) ? 7'h00 : bag_set;
            retry_d = '0;
            count_d = count_mid + 3'd1;
        end else begin
            count_d = count_mid;
            if (sampling) begin
                retry_d = retry_q + RW'(1);
            end
        end

        case (state_q)
            S_FILL: begin
                if (push && !take_eff && (count_d == DEPTH_C)) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (take_eff) begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FILL;
            count_q <= 3'd0;
            bag_q   <= 7'h00;
            retry_q <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                fifo_q[i] <= 3'd0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            bag_q   <= bag_d;
            retry_q <= retry_d;
            fifo_q  <= fifo_d;
        end
    end

    assign piece_valid   = (count_q != 3'd0);
    assign preview_valid = (count_q >= 3'd2);
    assign piece_id      = piece_valid   ? fifo_q[0] : 3'd0;
    assign preview_id    = preview_valid ? fifo_q[1] : 3'd0;
    assign queue_count   = count_q;
    assign bag_mask      = bag_q;

endmodule

// File: tb/tb_piece_scheduler.sv
module tb_piece_scheduler;

    logic       clk;
    logic       rst_n;
    logic [2:0] rand_in;
    logic       piece_take;
    logic       piece_valid;
    logic [2:0] piece_id;
    logic       preview_valid;
    logic [2:0] preview_id;
    logic [2:0] queue_count;
    logic [6:0] bag_mask;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    piece_scheduler #(.QUEUE_DEPTH(3), .MAX_RETRY(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rand_in      (rand_in),
        .piece_take   (piece_take),
        .piece_valid  (piece_valid),
        .piece_id     (piece_id),
        .preview_valid(preview_valid),
        .preview_id   (preview_id),
        .queue_count  (queue_count),
        .bag_mask     (bag_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int all_outs();
        return int'({piece_valid, piece_id, preview_valid, preview_id,
                     queue_count, bag_mask});
    endfunction

    task automatic take_expect(input int id);
        piece_take = 1'b1;
        exp_q.push_back(id);
    endtask

    // Scoreboard monitor: a take is consumed on the next rising edge, so the
    // head shown on the falling edge is the piece being handed out.
    always @(negedge clk) begin
        if (rst_n && piece_take && piece_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_take", 1, 0);
            end else begin
                chk("take_id", int'(piece_id), exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seq[7] = '{3, 4, 5, 6, 0, 1, 2};
        int issued;

        rst_n      = 1'b0;
        rand_in    = 3'd7;
        piece_take = 1'b0;
        #12;
        chk("reset_outputs", all_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Take with an empty queue is ignored.
        piece_take = 1'b1;
        tick();
        piece_take = 1'b0;
        chk("empty_take_outs", all_outs(), 0);

        // Fill 0,1,2.
        rand_in = 3'd0;
        tick();
        chk("fill1_count", int'(queue_count), 1);
        chk("fill1_id", int'(piece_id), 0);
        rand_in = 3'd1;
        tick();
        rand_in = 3'd2;
        tick();
        chk("fill3_count", int'(queue_count), 3);
        chk("fill3_head", int'(piece_id), 0);
        chk("fill3_prev", int'(preview_id), 1);
        chk("fill3_bag", int'(bag_mask), 7'h07);
        rand_in = 3'd7;
        tick();
        chk("full_hold_count", int'(queue_count), 3);

        // Take from full: no sample that cycle, then sampling resumes.
        rand_in = 3'd3;
        take_expect(0);
        tick();
        piece_take = 1'b0;
        chk("take_full_head", int'(piece_id), 1);
        chk("take_full_count", int'(queue_count), 2);
        tick();
        chk("resume_count", int'(queue_count), 3);
        chk("resume_bag", int'(bag_mask), 7'h0F);

        // Take + push in the same cycle, then bag refill on the 7th piece.
        rand_in = 3'd4;
        take_expect(1);
        tick();
        take_expect(2);
        tick();
        piece_take = 1'b0;
        chk("take_push_count", int'(queue_count), 2);
        chk("take_push_head", int'(piece_id), 3);
        chk("take_push_prev", int'(preview_id), 4);
        chk("take_push_bag", int'(bag_mask), 7'h1F);
        rand_in = 3'd5;
        tick();
        rand_in = 3'd6;
        take_expect(3);
        tick();
        piece_take = 1'b0;
        tick();
        chk("refill_bag", int'(bag_mask), 0);
        chk("refill_count", int'(queue_count), 3);
        chk("refill_head", int'(piece_id), 4);
        chk("refill_prev", int'(preview_id), 5);

        // Asynchronous reset mid-fill.
        rst_n = 1'b0;
        #1;
        chk("reset2_outputs", all_outs(), 0);
        chk("sb_empty1", exp_q.size(), 0);
        @(negedge clk);
        rst_n   = 1'b1;
        rand_in = 3'd0;
        tick();
        rand_in = 3'd1;
        tick();
        chk("midfill_count", int'(queue_count), 2);
        chk("midfill_bag", int'(bag_mask), 7'h03);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 0);
        rand_in = 3'd7;
        @(negedge clk);
        rst_n = 1'b1;

        // Forced picks after MAX_RETRY consecutive rejects.
        repeat (3) tick();
        chk("retry3_count", int'(queue_count), 0);
        tick();
        chk("force0_count", int'(queue_count), 1);
        chk("force0_id", int'(piece_id), 0);
        chk("force0_bag", int'(bag_mask), 7'h01);
        repeat (3) tick();
        chk("retry3b_count", int'(queue_count), 1);
        tick();
        chk("force1_count", int'(queue_count), 2);
        chk("force1_prev", int'(preview_id), 1);
        chk("force1_bag", int'(bag_mask), 7'h03);

        // Free-counting randomizer with a take on every valid head.
        rst_n = 1'b0;
        #1;
        rand_in = 3'd3;
        @(negedge clk);
        rst_n  = 1'b1;
        issued = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            tick();
            rand_in = rand_in + 3'd1;
            if (issued < 21 && piece_valid) begin
                take_expect(seq[issued % 7]);
                issued++;
            end else begin
                piece_take = 1'b0;
            end
            if (issued == 21 && exp_q.size() == 0) begin
                break;
            end
        end
        tick();
        piece_take = 1'b0;
        chk("bag_takes_issued", issued, 21);
        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
